// File: rtl/sm83_pkg.sv
// rtl/sm83_pkg.sv - shared SM83 stack-pointer IDU op and state encodings
package sm83_pkg;

  typedef enum logic [2:0] {
    SP_NOP      = 3'd0,
    SP_INC      = 3'd1,
    SP_DEC      = 3'd2,
    SP_LD_HL    = 3'd3,
    SP_LD_IMM   = 3'd4,
    SP_ADD_E8   = 3'd5,
    SP_LD_HL_E8 = 3'd6,
    SP_RSVD     = 3'd7
  } sm83_sp_op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WB     = 2'd1,
    ST_IMM_HI = 2'd2,
    ST_ADD_HI = 2'd3
  } sm83_sp_idu_state_t;

endpackage

// File: rtl/sm83_add8_hc.sv
// rtl/sm83_add8_hc.sv - 8-bit adder with carry-in, bit-3 and bit-7 carry outs
module sm83_add8_hc (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       c3,
  output logic       c7
);

  logic [4:0] lo;
  logic [4:0] hi;

  // Nibble split exposes the half-carry without a second adder.
  assign lo  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, cin};
  assign hi  = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'd0, lo[4]};
  assign sum = {hi[3:0], lo[3:0]};
  assign c3  = lo[4];
  assign c7  = hi[4];

endmodule

// File: rtl/sm83_sp_idu.sv
// rtl/sm83_sp_idu.sv - SM83 stack-pointer write-back controller with e8 add sequencing
module sm83_sp_idu
  import sm83_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [7:0]  imm,
  input  logic        imm_valid,
  input  logic [15:0] hl,
  input  logic [15:0] sp_q,
  output logic [15:0] sp_d,
  output logic        sp_we_lo,
  output logic        sp_we_hi,
  output logic [15:0] hl_d,
  output logic        hl_we,
  output logic        flag_h,
  output logic        flag_c,
  output logic        flag_we,
  output logic        busy,
  output logic        done
);

  sm83_sp_idu_state_t state, state_n;
  sm83_sp_op_t        op_c;

  logic [15:0] sp_d_n, hl_d_n;
  logic        sp_we_lo_n, sp_we_hi_n, hl_we_n;
  logic        flag_h_n, flag_c_n, flag_we_n, busy_n, done_n;

  // Operand state carried from the low-byte cycle into the high-byte cycle.
  logic        sign_r, sign_n;
  logic        carry_r, carry_n;
  logic [7:0]  lo_r, lo_n;
  logic        to_hl_r, to_hl_n;

  logic [7:0]  add_a, add_b, add_sum;
  logic        add_cin, add_c3, add_c7;

  assign op_c = sm83_sp_op_t'(op);

  // One adder: low byte at accept, sign-extended high byte in ADD_HI.
  assign add_a   = (state == ST_ADD_HI) ? sp_d[15:8]   : sp_q[7:0];
  assign add_b   = (state == ST_ADD_HI) ? {8{sign_r}}  : imm;
  assign add_cin = (state == ST_ADD_HI) ? carry_r      : 1'b0;

  sm83_add8_hc u_add (
    .a   (add_a),
    .b   (add_b),
    .cin (add_cin),
    .sum (add_sum),
    .c3  (add_c3),
    .c7  (add_c7)
  );

  always_comb begin
    state_n    = state;
    sp_d_n     = sp_d;
    hl_d_n     = hl_d;
    sp_we_lo_n = 1'b0;
    sp_we_hi_n = 1'b0;
    hl_we_n    = 1'b0;
    flag_h_n   = flag_h;
    flag_c_n   = flag_c;
    flag_we_n  = 1'b0;
    busy_n     = busy;
    done_n     = 1'b0;
    sign_n     = sign_r;
    carry_n    = carry_r;
    lo_n       = lo_r;
    to_hl_n    = to_hl_r;

    case (state)
      ST_IDLE: begin
        busy_n = 1'b0;
        if (start) begin
          busy_n = 1'b1;
          sp_d_n = sp_q;
          case (op_c)
            SP_INC, SP_DEC, SP_LD_HL: begin
              if (op_c == SP_INC)      sp_d_n = sp_q + 16'd1;
              else if (op_c == SP_DEC) sp_d_n = sp_q - 16'd1;
              else                     sp_d_n = hl;
              sp_we_lo_n = 1'b1;
              sp_we_hi_n = 1'b1;
              done_n     = 1'b1;
              state_n    = ST_WB;
            end
            SP_LD_IMM: begin
              sp_d_n     = {sp_q[15:8], imm};
              sp_we_lo_n = 1'b1;
              state_n    = ST_IMM_HI;
            end
            SP_ADD_E8, SP_LD_HL_E8: begin
              sign_n     = imm[7];
              carry_n    = add_c7;
              lo_n       = add_sum;
              to_hl_n    = (op_c == SP_LD_HL_E8);
              flag_h_n   = add_c3;
              flag_c_n   = add_c7;
              flag_we_n  = 1'b1;
              if (op_c == SP_ADD_E8) begin
                sp_d_n     = {sp_q[15:8], add_sum};
                sp_we_lo_n = 1'b1;
              end
              state_n    = ST_ADD_HI;
            end
            default: begin
              done_n  = 1'b1;
              state_n = ST_WB;
            end
          endcase
        end
      end
      ST_WB: begin
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end
      ST_IMM_HI: begin
        if (imm_valid) begin
          sp_d_n     = {imm, sp_d[7:0]};
          sp_we_hi_n = 1'b1;
          done_n     = 1'b1;
          state_n    = ST_WB;
        end
      end
      ST_ADD_HI: begin
        if (to_hl_r) begin
          hl_d_n  = {add_sum, lo_r};
          hl_we_n = 1'b1;
        end else begin
          sp_d_n     = {add_sum, lo_r};
          sp_we_hi_n = 1'b1;
        end
        done_n  = 1'b1;
        state_n = ST_WB;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      sp_d     <= 16'd0;
      hl_d     <= 16'd0;
      sp_we_lo <= 1'b0;
      sp_we_hi <= 1'b0;
      hl_we    <= 1'b0;
      flag_h   <= 1'b0;
      flag_c   <= 1'b0;
      flag_we  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sign_r   <= 1'b0;
      carry_r  <= 1'b0;
      lo_r     <= 8'd0;
      to_hl_r  <= 1'b0;
    end else begin
      state    <= state_n;
      sp_d     <= sp_d_n;
      hl_d     <= hl_d_n;
      sp_we_lo <= sp_we_lo_n;
      sp_we_hi <= sp_we_hi_n;
      hl_we    <= hl_we_n;
      flag_h   <= flag_h_n;
      flag_c   <= flag_c_n;
      flag_we  <= flag_we_n;
      busy     <= busy_n;
      done     <= done_n;
      sign_r   <= sign_n;
      carry_r  <= carry_n;
      lo_r     <= lo_n;
      to_hl_r  <= to_hl_n;
    end
  end

endmodule

// File: tb/tb_sm83_sp_idu.sv
// tb/tb_sm83_sp_idu.sv - directed self-checking bench for sm83_sp_idu
module tb_sm83_sp_idu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [7:0]  imm;
  logic        imm_valid;
  logic [15:0] hl;
  logic [15:0] sp_q;
  logic [15:0] sp_d;
  logic        sp_we_lo, sp_we_hi;
  logic [15:0] hl_d;
  logic        hl_we;
  logic        flag_h, flag_c, flag_we;
  logic        busy, done;

  // {sp_we_lo, sp_we_hi, hl_we, flag_we, done, busy}
  logic [5:0]  sig;
  assign sig = {sp_we_lo, sp_we_hi, hl_we, flag_we, done, busy};

  int n_cmp = 0;
  int n_fail = 0;

  sm83_sp_idu dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .imm       (imm),
    .imm_valid (imm_valid),
    .hl        (hl),
    .sp_q      (sp_q),
    .sp_d      (sp_d),
    .sp_we_lo  (sp_we_lo),
    .sp_we_hi  (sp_we_hi),
    .hl_d      (hl_d),
    .hl_we     (hl_we),
    .flag_h    (flag_h),
    .flag_c    (flag_c),
    .flag_we   (flag_we),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Drives a request at a falling edge; returns at the falling edge of N+1.
  task automatic go(input logic [2:0] o, input logic [7:0] i, input logic [15:0] s);
    op = o; imm = i; sp_q = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; op = 3'd0; imm = 8'd0; imm_valid = 1'b0;
    hl = 16'd0; sp_q = 16'd0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({sp_d, hl_d, sig, flag_h, flag_c} !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_state got sp_d=%h hl_d=%h sig=%b hc=%b%b want all 0", sp_d, hl_d, sig, flag_h, flag_c);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_inc_dec_wrap;
    go(3'd1, 8'd0, 16'hFFFF);
    n_cmp++;
    if (sp_d !== 16'h0000) begin n_fail++; $display("FAIL inc_wrap sp_d got %h want 0000", sp_d); end
    n_cmp++;
    if (sig !== 6'b110011) begin n_fail++; $display("FAIL inc_wrap sig got %b want 110011", sig); end
    @(negedge clk);
    n_cmp++;
    if (sig !== 6'b000000) begin n_fail++; $display("FAIL inc_after sig got %b want 000000", sig); end
    go(3'd2, 8'd0, 16'h0000);
    n_cmp++;
    if (sp_d !== 16'hFFFF) begin n_fail++; $display("FAIL dec_wrap sp_d got %h want FFFF", sp_d); end
    n_cmp++;
    if (sig !== 6'b110011) begin n_fail++; $display("FAIL dec_wrap sig got %b want 110011", sig); end
    @(negedge clk);
  endtask

  task automatic test_ld_hl_nop;
    hl = 16'hBEEF;
    go(3'd3, 8'd0, 16'h1234);
    n_cmp++;
    if (sp_d !== 16'hBEEF) begin n_fail++; $display("FAIL ld_hl sp_d got %h want BEEF", sp_d); end
    n_cmp++;
    if (sig !== 6'b110011) begin n_fail++; $display("FAIL ld_hl sig got %b want 110011", sig); end
    @(negedge clk);
    go(3'd0, 8'd0, 16'h5555);
    n_cmp++;
    if (sig !== 6'b000011) begin n_fail++; $display("FAIL nop sig got %b want 000011", sig); end
    @(negedge clk);
    go(3'd7, 8'd0, 16'h5555);
    n_cmp++;
    if (sig !== 6'b000011) begin n_fail++; $display("FAIL reserved sig got %b want 000011", sig); end
    @(negedge clk);
  endtask

  task automatic test_add_e8;
    logic [15:0] v_sp  [4] = '{16'hFFF8, 16'h1000, 16'hFFFF, 16'h000F};
    logic [7:0]  v_imm [4] = '{8'h08,    8'hFF,    8'h01,    8'h01};
    logic [15:0] v_lo  [4] = '{16'hFF00, 16'h10FF, 16'hFF00, 16'h0010};
    logic [1:0]  v_hc  [4] = '{2'b11,    2'b00,    2'b11,    2'b10};
    logic [15:0] v_res [4] = '{16'h0000, 16'h0FFF, 16'h0000, 16'h0010};
    for (int k = 0; k < 4; k++) begin
      go(3'd5, v_imm[k], v_sp[k]);
      n_cmp++;
      if (sp_d !== v_lo[k]) begin n_fail++; $display("FAIL add_e8_lo[%0d] sp_d got %h want %h", k, sp_d, v_lo[k]); end
      n_cmp++;
      if ({flag_h, flag_c} !== v_hc[k]) begin n_fail++; $display("FAIL add_e8_hc[%0d] got %b%b want %b", k, flag_h, flag_c, v_hc[k]); end
      n_cmp++;
      if (sig !== 6'b100101) begin n_fail++; $display("FAIL add_e8_sig1[%0d] got %b want 100101", k, sig); end
      @(negedge clk);
      n_cmp++;
      if (sp_d !== v_res[k]) begin n_fail++; $display("FAIL add_e8_hi[%0d] sp_d got %h want %h", k, sp_d, v_res[k]); end
      n_cmp++;
      if (sig !== 6'b010011) begin n_fail++; $display("FAIL add_e8_sig2[%0d] got %b want 010011", k, sig); end
      @(negedge clk);
    end
  endtask

  task automatic test_ld_hl_e8;
    go(3'd6, 8'hFE, 16'h0005);
    n_cmp++;
    if ({flag_h, flag_c} !== 2'b11) begin n_fail++; $display("FAIL ldhle8_hc got %b%b want 11", flag_h, flag_c); end
    n_cmp++;
    if (sig !== 6'b000101) begin n_fail++; $display("FAIL ldhle8_sig1 got %b want 000101", sig); end
    @(negedge clk);
    n_cmp++;
    if (hl_d !== 16'h0003) begin n_fail++; $display("FAIL ldhle8_hl_d got %h want 0003", hl_d); end
    n_cmp++;
    if (sig !== 6'b001011) begin n_fail++; $display("FAIL ldhle8_sig2 got %b want 001011", sig); end
    n_cmp++;
    if (sp_d !== 16'h0005) begin n_fail++; $display("FAIL ldhle8_sp_d got %h want 0005", sp_d); end
    @(negedge clk);
  endtask

  task automatic test_ld_imm;
    imm_valid = 1'b1; imm = 8'h77;
    @(negedge clk);
    imm_valid = 1'b0;
    n_cmp++;
    if (sig !== 6'b000000 || sp_d !== 16'h0005) begin
      n_fail++; $display("FAIL imm_valid_idle got sig=%b sp_d=%h want 000000 0005", sig, sp_d);
    end
    go(3'd4, 8'h34, 16'hABCD);
    n_cmp++;
    if (sp_d !== 16'hAB34) begin n_fail++; $display("FAIL ld_imm_lo sp_d got %h want AB34", sp_d); end
    n_cmp++;
    if (sig !== 6'b100001) begin n_fail++; $display("FAIL ld_imm_lo sig got %b want 100001", sig); end
    start = 1'b1; op = 3'd1; imm = 8'h99;
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if (sig !== 6'b000001) begin n_fail++; $display("FAIL ld_imm_wait sig got %b want 000001", sig); end
    end
    start = 1'b0; imm_valid = 1'b1; imm = 8'h12;
    @(negedge clk);
    imm_valid = 1'b0;
    n_cmp++;
    if (sp_d !== 16'h1234) begin n_fail++; $display("FAIL ld_imm_hi sp_d got %h want 1234", sp_d); end
    n_cmp++;
    if (sig !== 6'b010011) begin n_fail++; $display("FAIL ld_imm_hi sig got %b want 010011", sig); end
    @(negedge clk);
    n_cmp++;
    if (sig !== 6'b000000) begin n_fail++; $display("FAIL ld_imm_noqueue sig got %b want 000000", sig); end
    go(3'd4, 8'h56, 16'h0000);
    imm_valid = 1'b1; imm = 8'h78;
    @(negedge clk);
    imm_valid = 1'b0;
    n_cmp++;
    if (sp_d !== 16'h7856 || sig !== 6'b010011) begin
      n_fail++; $display("FAIL ld_imm_early got sp_d=%h sig=%b want 7856 010011", sp_d, sig);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_add;
    go(3'd5, 8'h08, 16'hFFF8);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({sp_d, hl_d, sig, flag_h, flag_c} !== 40'd0) begin
      n_fail++; $display("FAIL reset_mid got sp_d=%h hl_d=%h sig=%b want all 0", sp_d, hl_d, sig);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (sig !== 6'b000000) begin n_fail++; $display("FAIL reset_mid_after sig got %b want 000000", sig); end
    go(3'd1, 8'd0, 16'h0041);
    n_cmp++;
    if (sp_d !== 16'h0042 || sig !== 6'b110011) begin
      n_fail++; $display("FAIL reset_mid_restart got sp_d=%h sig=%b want 0042 110011", sp_d, sig);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int writes = 0;
    sp_q = 16'h0100; op = 3'd1; start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (done !== ((i % 2) == 0)) begin n_fail++; $display("FAIL b2b_done[%0d] got %b want %b", i, done, (i % 2) == 0); end
      if (sp_we_lo && sp_we_hi) begin
        n_cmp++;
        if (sp_d !== 16'h0101 + 16'(writes)) begin
          n_fail++; $display("FAIL b2b_value[%0d] got %h want %h", writes, sp_d, 16'h0101 + 16'(writes));
        end
        sp_q = sp_d;
        writes++;
      end
    end
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (writes != 3) begin n_fail++; $display("FAIL b2b_writes got %0d want 3", writes); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_inc_dec_wrap;
    test_ld_hl_nop;
    test_add_e8;
    test_ld_hl_e8;
    test_ld_imm;
    test_reset_mid_add;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
